// File: rtl/op_dispatcher_if.sv
// Command/response channel between a host and the operator dispatcher.
// master drives commands and consumes responses; slave is the dispatcher.
interface op_dispatcher_if #(
  parameter int ADRBW = 20,
  parameter int VARBW = 16
);
  logic             i_cmd_valid;
  logic             o_cmd_ready;
  logic [1:0]       i_cmd_op;
  logic [ADRBW-1:0] i_x1addr;
  logic [ADRBW-1:0] i_x2addr;
  logic [ADRBW-1:0] i_x3addr;
  logic [VARBW-1:0] i_varsize_x1;
  logic [VARBW-1:0] i_varsize_x2;
  logic             o_rsp_valid;
  logic             i_rsp_ready;
  logic [1:0]       o_rsp_err;
  logic [VARBW-1:0] o_varsize_x3;

  modport master (
    output i_cmd_valid, i_cmd_op,
    output i_x1addr, i_x2addr, i_x3addr,
    output i_varsize_x1, i_varsize_x2,
    output i_rsp_ready,
    input  o_cmd_ready, o_rsp_valid,
    input  o_rsp_err, o_varsize_x3
  );

  modport slave (
    input  i_cmd_valid, i_cmd_op,
    input  i_x1addr, i_x2addr, i_x3addr,
    input  i_varsize_x1, i_varsize_x2,
    input  i_rsp_ready,
    output o_cmd_ready, o_rsp_valid,
    output o_rsp_err, o_varsize_x3
  );
endinterface

// File: rtl/op_dispatcher.sv
// Dispatches add/mul commands to arithmetic units, arbitrates the shared
// SRAM write port and guards each operation with a watchdog.
module op_dispatcher #(
  parameter int ADRBW = 20,
  parameter int WRDBW = 16,
  parameter int VARBW = 16,
  parameter int TMOBW = 20
) (
  input  logic             i_clk,
  input  logic             i_rst,
  op_dispatcher_if.slave   bus,
  output logic [ADRBW-1:0] o_x1addr,
  output logic [ADRBW-1:0] o_x2addr,
  output logic [ADRBW-1:0] o_x3addr,
  output logic [VARBW-1:0] o_varsize_x1,
  output logic [VARBW-1:0] o_varsize_x2,
  output logic             o_add_valid,
  output logic             o_mul_valid,
  output logic             o_abort,
  input  logic             i_add_wen,
  input  logic [ADRBW-1:0] i_add_addr,
  input  logic [WRDBW-1:0] i_add_wdata,
  input  logic [VARBW-1:0] i_add_varsize_x3,
  input  logic             i_add_done,
  input  logic             i_mul_wen,
  input  logic [ADRBW-1:0] i_mul_addr,
  input  logic [WRDBW-1:0] i_mul_wdata,
  input  logic [VARBW-1:0] i_mul_varsize_x3,
  input  logic             i_mul_done,
  output logic             o_sram_wen,
  output logic [ADRBW-1:0] o_sram_addr,
  output logic [WRDBW-1:0] o_sram_wdata,
  input  logic [WRDBW-1:0] i_sram_rdata,
  output logic [WRDBW-1:0] o_unit_rdata
);

  typedef enum logic [1:0] {
    IDLE, ISSUE, BUSY, RESP
  } state_e;

  // Last BUSY cycle before the counter would hit 2^TMOBW-1.
  localparam logic [TMOBW-1:0] WD_LAST =
    {{(TMOBW-1){1'b1}}, 1'b0};
  localparam logic [TMOBW-1:0] WD_ONE =
    {{(TMOBW-1){1'b0}}, 1'b1};

  state_e           state_q;
  logic             mul_q;
  logic [TMOBW-1:0] wdog_q;
  logic [1:0]       err_q;
  logic [VARBW-1:0] vs3_q;
  logic             add_valid_q;
  logic             mul_valid_q;
  logic             sel_done;
  logic [VARBW-1:0] sel_vs;

  always_comb begin
    sel_done     = mul_q ? i_mul_done : i_add_done;
    sel_vs       = mul_q ? i_mul_varsize_x3
                         : i_add_varsize_x3;
    o_sram_wen   = 1'b0;
    o_sram_addr  = '0;
    o_sram_wdata = '0;
    if (state_q == BUSY) begin
      o_sram_wen   = mul_q ? i_mul_wen : i_add_wen;
      o_sram_addr  = mul_q ? i_mul_addr : i_add_addr;
      o_sram_wdata = mul_q ? i_mul_wdata
                           : i_add_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      mul_q        <= 1'b0;
      wdog_q       <= '0;
      err_q        <= '0;
      vs3_q        <= '0;
      add_valid_q  <= 1'b0;
      mul_valid_q  <= 1'b0;
      o_x1addr     <= '0;
      o_x2addr     <= '0;
      o_x3addr     <= '0;
      o_varsize_x1 <= '0;
      o_varsize_x2 <= '0;
    end else begin
      add_valid_q <= 1'b0;
      mul_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.i_cmd_valid) begin
            mul_q        <= bus.i_cmd_op[0];
            o_x1addr     <= bus.i_x1addr;
            o_x2addr     <= bus.i_x2addr;
            o_x3addr     <= bus.i_x3addr;
            o_varsize_x1 <= bus.i_varsize_x1;
            o_varsize_x2 <= bus.i_varsize_x2;
            if (bus.i_cmd_op[1]) begin
              err_q   <= 2'b01;
              vs3_q   <= '0;
              state_q <= RESP;
            end else if (bus.i_varsize_x1 == '0 ||
                         bus.i_varsize_x2 == '0) begin
              err_q   <= 2'b10;
              vs3_q   <= '0;
              state_q <= RESP;
            end else begin
              add_valid_q <= ~bus.i_cmd_op[0];
              mul_valid_q <= bus.i_cmd_op[0];
              state_q     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          wdog_q  <= '0;
          state_q <= BUSY;
        end
        BUSY: begin
          wdog_q <= wdog_q + WD_ONE;
          if (sel_done) begin
            err_q   <= 2'b00;
            vs3_q   <= sel_vs;
            state_q <= RESP;
          end else if (wdog_q == WD_LAST) begin
            err_q   <= 2'b11;
            vs3_q   <= '0;
            state_q <= RESP;
          end
        end
        RESP: begin
          if (bus.i_rsp_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_abort = (state_q == BUSY) && !sel_done &&
                   (wdog_q == WD_LAST);

  assign o_add_valid      = add_valid_q;
  assign o_mul_valid      = mul_valid_q;
  assign o_unit_rdata     = i_sram_rdata;
  assign bus.o_cmd_ready  = (state_q == IDLE);
  assign bus.o_rsp_valid  = (state_q == RESP);
  assign bus.o_rsp_err    = err_q;
  assign bus.o_varsize_x3 = vs3_q;

endmodule
